// File: rtl/any1_pkg.sv
// Shared definitions for the any1 load/store path: size codes, load-align states and helpers.
// Size codes 3 and 7 both mean an 8-byte access.
package any1_pkg;

   localparam logic [3:0] SZ_BYTE  = 4'd0;
   localparam logic [3:0] SZ_WYDE  = 4'd1;
   localparam logic [3:0] SZ_TETRA = 4'd2;
   localparam logic [3:0] SZ_OCTA  = 4'd3;
   localparam logic [3:0] SZ_OCTA2 = 4'd7;

   typedef enum logic [1:0] {
      LA_IDLE,
      LA_RD1,
      LA_RD2,
      LA_DONE
   } load_state_t;

   function automatic logic size_ok(input logic [3:0] sz);
      return (sz == SZ_BYTE) || (sz == SZ_WYDE) || (sz == SZ_TETRA) ||
             (sz == SZ_OCTA) || (sz == SZ_OCTA2);
   endfunction

   function automatic logic [7:0] size_mask(input logic [3:0] sz);
      case (sz)
         SZ_BYTE:  return 8'h01;
         SZ_WYDE:  return 8'h03;
         SZ_TETRA: return 8'h0F;
         default:  return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/any1_load_extend.sv
// Shifts the addressed bytes of a merged two-beat window down to bit 0, then zero/sign-extends.
// Purely combinational; octa sizes pass the shifted data through untouched.
module any1_load_extend
   import any1_pkg::*;
(
   input  logic [127:0] dat,
   input  logic [2:0]   ofs,
   input  logic [3:0]   sz,
   input  logic         sgn,
   output logic [63:0]  res
);

   logic [63:0] sh;

   assign sh = 64'(dat >> {ofs, 3'b000});

   always_comb begin
      res = sh;
      case (sz)
         SZ_BYTE:  res = {{56{sgn & sh[7]}},  sh[7:0]};
         SZ_WYDE:  res = {{48{sgn & sh[15]}}, sh[15:0]};
         SZ_TETRA: res = {{32{sgn & sh[31]}}, sh[31:0]};
         default:  res = sh;
      endcase
   end

endmodule

// File: rtl/any1_load_align.sv
// Load aligner: one or two 64-bit bus beats per request, merged, shifted and extended.
// Result held in DONE until res_rdy_i; req_rdy_o is a registered IDLE flag.
module any1_load_align
   import any1_pkg::*;
#(
   parameter int AWID = 32
)(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req_i,
   output logic            req_rdy_o,
   input  logic [AWID-1:0] req_adr_i,
   input  logic [3:0]      req_sz_i,
   input  logic            req_sgn_i,
   input  logic [5:0]      req_tag_i,
   output logic            cyc_o,
   output logic            stb_o,
   output logic [AWID-1:0] adr_o,
   output logic [7:0]      sel_o,
   input  logic            ack_i,
   input  logic            err_i,
   input  logic [63:0]     dat_i,
   output logic            res_v_o,
   input  logic            res_rdy_i,
   output logic [63:0]     res_o,
   output logic [5:0]      res_tag_o,
   output logic            res_err_o
);

   load_state_t state;
   logic [2:0]  ofs;
   logic [3:0]  sz;
   logic        sgn;
   logic [7:0]  sel_hi;
   logic [63:0] lo;
   logic [15:0] req_mask;
   logic [127:0] merged;
   logic [63:0] ext;
   logic        bus_done;

   assign req_mask = {8'h00, size_mask(req_sz_i)} << req_adr_i[2:0];
   assign bus_done = stb_o & (ack_i | err_i);
   // The terminating beat is merged straight from the bus so the result registers on that edge.
   assign merged   = (state == LA_RD2) ? {dat_i, lo} : {64'h0, dat_i};

   any1_load_extend u_extend (
      .dat (merged),
      .ofs (ofs),
      .sz  (sz),
      .sgn (sgn),
      .res (ext)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= LA_IDLE;
         ofs       <= '0;
         sz        <= '0;
         sgn       <= 1'b0;
         sel_hi    <= '0;
         lo        <= '0;
         req_rdy_o <= 1'b1;
         cyc_o     <= 1'b0;
         stb_o     <= 1'b0;
         adr_o     <= '0;
         sel_o     <= '0;
         res_v_o   <= 1'b0;
         res_o     <= '0;
         res_tag_o <= '0;
         res_err_o <= 1'b0;
      end else begin
         case (state)
            LA_IDLE: begin
               if (req_i) begin
                  ofs       <= req_adr_i[2:0];
                  sz        <= req_sz_i;
                  sgn       <= req_sgn_i;
                  sel_hi    <= req_mask[15:8];
                  res_tag_o <= req_tag_i;
                  req_rdy_o <= 1'b0;
                  if (!size_ok(req_sz_i)) begin
                     state     <= LA_DONE;
                     res_v_o   <= 1'b1;
                     res_err_o <= 1'b1;
                     res_o     <= '0;
                  end else begin
                     state <= LA_RD1;
                     cyc_o <= 1'b1;
                     stb_o <= 1'b1;
                     adr_o <= {req_adr_i[AWID-1:3], 3'b000};
                     sel_o <= req_mask[7:0];
                  end
               end
            end
            LA_RD1, LA_RD2: begin
               if (bus_done) begin
                  if (!err_i && state == LA_RD1 && sel_hi != 8'h00) begin
                     state <= LA_RD2;
                     lo    <= dat_i;
                     adr_o <= adr_o + AWID'(8);
                     sel_o <= sel_hi;
                  end else begin
                     state     <= LA_DONE;
                     cyc_o     <= 1'b0;
                     stb_o     <= 1'b0;
                     sel_o     <= '0;
                     res_v_o   <= 1'b1;
                     res_err_o <= err_i;
                     res_o     <= err_i ? 64'h0 : ext;
                  end
               end
            end
            LA_DONE: begin
               if (res_rdy_i) begin
                  state     <= LA_IDLE;
                  res_v_o   <= 1'b0;
                  req_rdy_o <= 1'b1;
               end
            end
            default: state <= LA_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_any1_load_align.sv
// Directed bench for any1_load_align with a result scoreboard and per-cycle bus/timing checks.
module tb_any1_load_align;

   localparam int AWID = 32;

   logic            clk = 1'b0;
   logic            rst_ni;
   logic            req_i;
   logic            req_rdy_o;
   logic [AWID-1:0] req_adr_i;
   logic [3:0]      req_sz_i;
   logic            req_sgn_i;
   logic [5:0]      req_tag_i;
   logic            cyc_o, stb_o;
   logic [AWID-1:0] adr_o;
   logic [7:0]      sel_o;
   logic            ack_i, err_i;
   logic [63:0]     dat_i;
   logic            res_v_o, res_rdy_i;
   logic [63:0]     res_o;
   logic [5:0]      res_tag_o;
   logic            res_err_o;

   int checks = 0;
   int passes = 0;

   logic [63:0] exp_res_q[$];
   logic        exp_err_q[$];
   logic [5:0]  exp_tag_q[$];

   always #5 clk = ~clk;

   any1_load_align #(.AWID(AWID)) dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
      .req_i     (req_i),
      .req_rdy_o (req_rdy_o),
      .req_adr_i (req_adr_i),
      .req_sz_i  (req_sz_i),
      .req_sgn_i (req_sgn_i),
      .req_tag_i (req_tag_i),
      .cyc_o     (cyc_o),
      .stb_o     (stb_o),
      .adr_o     (adr_o),
      .sel_o     (sel_o),
      .ack_i     (ack_i),
      .err_i     (err_i),
      .dat_i     (dat_i),
      .res_v_o   (res_v_o),
      .res_rdy_i (res_rdy_i),
      .res_o     (res_o),
      .res_tag_o (res_tag_o),
      .res_err_o (res_err_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Drives one request cycle; expected result goes to the scoreboard when push is set.
   task automatic send(input logic [31:0] a, input logic [3:0] sz, input logic sg,
                       input logic [5:0] tg, input logic [63:0] er, input logic ee,
                       input bit push);
      chk("req_rdy_before_req", {63'h0, req_rdy_o}, 64'd1);
      req_i = 1'b1; req_adr_i = a; req_sz_i = sz; req_sgn_i = sg; req_tag_i = tg;
      if (push) begin
         exp_res_q.push_back(er);
         exp_err_q.push_back(ee);
         exp_tag_q.push_back(tg);
      end
      tick();
      req_i = 1'b0;
   endtask

   // Checks the strobed beat, then terminates it with ack or err.
   task automatic beat(input string tg, input logic [31:0] ea, input logic [7:0] es,
                       input logic [63:0] d, input bit e);
      chk({tg, "_cyc"}, {63'h0, cyc_o}, 64'd1);
      chk({tg, "_stb"}, {63'h0, stb_o}, 64'd1);
      chk({tg, "_adr"}, {32'h0, adr_o}, {32'h0, ea});
      chk({tg, "_sel"}, {56'h0, sel_o}, {56'h0, es});
      dat_i = d; ack_i = !e; err_i = e;
      tick();
      ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
   endtask

   task automatic pop_result(input string tg, input int budget);
      int n = 0;
      while (!res_v_o && n < budget) begin
         tick();
         n++;
      end
      chk({tg, "_res_v"}, {63'h0, res_v_o}, 64'd1);
      if (exp_res_q.size() == 0) begin
         chk({tg, "_sb_nonempty"}, 64'd0, {32'h0, 32'(exp_res_q.size() + 1)});
      end else begin
         chk({tg, "_res"},     res_o,              exp_res_q.pop_front());
         chk({tg, "_res_err"}, {63'h0, res_err_o}, {63'h0, exp_err_q.pop_front()});
         chk({tg, "_res_tag"}, {58'h0, res_tag_o}, {58'h0, exp_tag_q.pop_front()});
      end
      res_rdy_i = 1'b1;
      tick();
      res_rdy_i = 1'b0;
      chk({tg, "_idle_rdy"}, {63'h0, req_rdy_o}, 64'd1);
      chk({tg, "_idle_v"},   {63'h0, res_v_o},   64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni = 1'b0; req_i = 1'b0; req_adr_i = '0; req_sz_i = '0; req_sgn_i = 1'b0;
      req_tag_i = '0; ack_i = 1'b0; err_i = 1'b0; dat_i = '0; res_rdy_i = 1'b0;
      tick(); tick();
      chk("rst_cyc",     {63'h0, cyc_o},     64'd0);
      chk("rst_stb",     {63'h0, stb_o},     64'd0);
      chk("rst_adr",     {32'h0, adr_o},     64'd0);
      chk("rst_sel",     {56'h0, sel_o},     64'd0);
      chk("rst_res_v",   {63'h0, res_v_o},   64'd0);
      chk("rst_res",     res_o,              64'd0);
      chk("rst_tag",     {58'h0, res_tag_o}, 64'd0);
      chk("rst_err",     {63'h0, res_err_o}, 64'd0);
      chk("rst_req_rdy", {63'h0, req_rdy_o}, 64'd1);
      rst_ni = 1'b1;
      tick();

      // Signed byte at offset 5: single beat, result in cycle 2.
      send(32'h1005, 4'd0, 1'b1, 6'h05, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b1);
      chk("b1_rdy_busy", {63'h0, req_rdy_o}, 64'd0);
      beat("b1", 32'h1000, 8'h20, 64'h0000_8000_0000_0000, 1'b0);
      chk("b1_v_cycle2", {63'h0, res_v_o}, 64'd1);
      chk("b1_cyc_off",  {63'h0, cyc_o},   64'd0);
      pop_result("b1", 4);

      // Straddling unsigned tetra: cyc held between beats, result in cycle 3.
      send(32'h100E, 4'd2, 1'b0, 6'h09, 64'h0000_0000_DDCC_BBAA, 1'b0, 1'b1);
      beat("t1a", 32'h1008, 8'hC0, 64'hBBAA_0000_0000_0000, 1'b0);
      beat("t1b", 32'h1010, 8'h03, 64'h0000_0000_0000_DDCC, 1'b0);
      chk("t1_v_cycle3", {63'h0, res_v_o}, 64'd1);
      pop_result("t1", 4);

      // Bus error on beat 1 of a straddling wyde: no second beat.
      send(32'h2007, 4'd1, 1'b1, 6'h11, 64'h0, 1'b1, 1'b1);
      beat("w_err", 32'h2000, 8'h80, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      chk("w_err_cyc", {63'h0, cyc_o},   64'd0);
      chk("w_err_v",   {63'h0, res_v_o}, 64'd1);
      pop_result("w_err", 4);

      // Invalid size code 5: no bus cycle, result in cycle 1.
      send(32'h2000, 4'd5, 1'b0, 6'h15, 64'h0, 1'b1, 1'b1);
      chk("inv_v_cycle1", {63'h0, res_v_o}, 64'd1);
      chk("inv_cyc",      {63'h0, cyc_o},   64'd0);
      pop_result("inv", 4);

      // Aligned octa with one wait state, then five cycles of result backpressure.
      send(32'h3000, 4'd3, 1'b1, 6'h2A, 64'h8123_4567_89AB_CDEF, 1'b0, 1'b1);
      chk("o_wait_stb", {63'h0, stb_o}, 64'd1);
      tick();
      beat("o", 32'h3000, 8'hFF, 64'h8123_4567_89AB_CDEF, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("bp_res",     res_o,              64'h8123_4567_89AB_CDEF);
         chk("bp_tag",     {58'h0, res_tag_o}, 64'h2A);
         chk("bp_req_rdy", {63'h0, req_rdy_o}, 64'd0);
         tick();
      end
      pop_result("o", 2);

      // Back-to-back request in the IDLE cycle: size 7 octa straddling, sgn ignored.
      send(32'h3003, 4'd7, 1'b1, 6'h33, 64'hCCBB_AA88_7766_5544, 1'b0, 1'b1);
      beat("o7a", 32'h3000, 8'hF8, 64'h8877_6655_4433_2211, 1'b0);
      beat("o7b", 32'h3008, 8'h07, 64'hFFFF_FFFF_FFCC_BBAA, 1'b0);
      pop_result("o7", 4);

      // Signed wyde with the sign bit set.
      send(32'h4006, 4'd1, 1'b1, 6'h01, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b1);
      beat("ws", 32'h4000, 8'hC0, 64'h8001_0000_0000_0000, 1'b0);
      pop_result("ws", 4);

      // Second beat address wraps past the top of the address space.
      send(32'hFFFF_FFFE, 4'd2, 1'b1, 6'h3F, 64'h0000_0000_4433_2211, 1'b0, 1'b1);
      beat("wrap_a", 32'hFFFF_FFF8, 8'hC0, 64'h2211_0000_0000_0000, 1'b0);
      beat("wrap_b", 32'h0000_0000, 8'h03, 64'hDEAD_0000_0000_4433, 1'b0);
      pop_result("wrap", 4);

      // Reset pulsed during an RD2 wait state.
      send(32'h5006, 4'd2, 1'b0, 6'h07, 64'h0, 1'b0, 1'b0);
      beat("rst_a", 32'h5000, 8'hC0, 64'h1234_0000_0000_0000, 1'b0);
      chk("rst_rd2_stb", {63'h0, stb_o}, 64'd1);
      chk("rst_rd2_adr", {32'h0, adr_o}, 64'h5008);
      #2 rst_ni = 1'b0;
      #1;
      chk("rst_async_cyc", {63'h0, cyc_o}, 64'd0);
      chk("rst_async_stb", {63'h0, stb_o}, 64'd0);
      tick();
      rst_ni = 1'b1;
      tick();
      chk("rst_after_rdy", {63'h0, req_rdy_o}, 64'd1);
      chk("rst_after_v",   {63'h0, res_v_o},   64'd0);
      tick();
      chk("rst_no_result", {63'h0, res_v_o},   64'd0);
      chk("sb_empty", {32'h0, 32'(exp_res_q.size())}, 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
